pkt_rr_scheduler: RTL



---
 rtl/pkt_rr_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pkt_rr_scheduler.sv
// Packet-level round-robin scheduler: grants one engine at a time, forwards its
// whole header+payload packet to a single output stream, then rotates priority.
module pkt_rr_scheduler #(
    parameter int NUM_ENG    = 2,
    parameter int SEL_W      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_ENG-1:0]            in_valid,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] in_data,
    output logic [NUM_ENG-1:0]            in_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [SEL_W-1:0]              out_sel,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD
    } state_t;

    state_t                r_state;
    logic [SEL_W-1:0]      r_grant;
    logic [SEL_W-1:0]      r_last_grant;
    logic [LEN_WIDTH:0]    r_beats_left;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    logic                  w_active;
    logic                  w_grant_valid;
    logic [DATA_WIDTH-1:0] w_grant_data;
    logic [LEN_WIDTH-1:0]  w_len;
    logic [LEN_WIDTH:0]    w_hdr_beats;
    logic [SEL_W-1:0]      w_pick;
    logic                  w_fire;
    logic                  w_done;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_data  = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (r_grant == SEL_W'(i)) begin
                w_grant_valid = in_valid[i];
                w_grant_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Scan last_grant+1, +2, ... ; descending k lets the nearest requester win.
    always_comb begin
        w_pick = r_last_grant;
        for (int k = NUM_ENG; k >= 1; k--) begin
            for (int i = 0; i < NUM_ENG; i++) begin
                if (r_last_grant == SEL_W'(i) && in_valid[(i + k) % NUM_ENG]) begin
                    w_pick = SEL_W'((i + k) % NUM_ENG);
                end
            end
        end
    end

    // One extra bit keeps len = 2^LEN_WIDTH-1 from wrapping when rounding up.
    assign w_len       = w_grant_data[LEN_WIDTH-1:0];
    assign w_hdr_beats = ({1'b0, w_len} + (LEN_WIDTH+1)'(7)) >> 3;

    assign w_active  = (r_state != ST_IDLE);
    assign out_valid = !reset && w_active && w_grant_valid;
    assign out_last  = !reset &&
                       (((r_state == ST_HEADER)  && (w_hdr_beats == '0)) ||
                        ((r_state == ST_PAYLOAD) && (r_beats_left == (LEN_WIDTH+1)'(1))));
    assign out_data  = w_active ? w_grant_data : '0;
    assign out_sel   = r_grant;
    assign busy      = w_active;
    assign pkt_count = r_pkt_count;
    assign w_fire    = out_valid && out_ready;
    assign w_done    = w_fire && out_last;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (!reset && w_active && (r_grant == SEL_W'(i))) begin
                in_ready[i] = out_ready;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; the completion update below overrides the case.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= SEL_W'(NUM_ENG - 1);
            r_beats_left <= '0;
            r_pkt_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|in_valid) begin
                        r_grant <= w_pick;
                        r_state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (w_fire && !w_done) begin
                        r_beats_left <= w_hdr_beats;
                        r_state      <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_fire) begin
                        r_beats_left <= r_beats_left - (LEN_WIDTH+1)'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_done) begin
                r_last_grant <= r_grant;
                r_pkt_count  <= r_pkt_count + CNT_WIDTH'(1);
                r_state      <= ST_IDLE;
            end
        end
    end

endmodule
